pwm_multi: RTL
==============

# pwm_multi

Parametrised multi-channel PWM generator. It drives CHANNELS outputs from one shared period counter, with a programmable prescaler, period and duty. Edge-aligned or center-aligned mode is selectable, outputs have per-channel polarity, and double-buffered (shadow) duty registers update glitch-free on period boundaries. It replaces single-channel fixed-255 PWM instances wherever several LEDs or motors share a timebase.

## Interface
- WIDTH, 8: counter, period and duty width.
- CHANNELS, 4: number of PWM outputs.
- PRE_W, 8: prescaler width.
- SEL_W, 2: duty_sel width; must be at least clog2(CHANNELS).

- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  enable; low freezes prescaler, counter, direction and outputs.
- prescale  in  PRE_W  counter advances once every prescale+1 enabled cycles.
- period  in  WIDTH  period value P, latched at the boundary.
- center  in  1  mode select, latched at the boundary: 0 edge-aligned, 1 center-aligned.
- polarity  in  CHANNELS  per-channel inversion, applied live.
- duty_wr  in  1  write strobe for the shadow duty register.
- duty_sel  in  SEL_W  channel index for the write.
- duty_data  in  WIDTH  duty value D.
- out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  one-cycle pulse when the counter restarts at 0.

## Operation
- Reset priority: rst overrides en and duty_wr. On reset:
  - pre_cnt=0, cnt=0, dir=up.
  - All shadow and active duties = 0.
  - Active period = 0, active mode = edge.
  - out = 0, period_start = 0.
- Prescaler:
  - The prescaler runs only while en=1.
  - tick = (pre_cnt==prescale); on a tick pre_cnt returns to 0, otherwise it increments.
  - prescale=0 gives a tick every enabled cycle.
- Counter:
  - cnt moves only on a tick.
  - Edge mode sequence: 0,1,…,P,0. That is P+1 ticks per period.
  - Center mode sequence: 0,1,…,P,P-1,…,1,0. That is 2P ticks per period.
  - dir flips to down when cnt reaches P, and flips back to up when cnt reaches 0.
  - P=0 in either mode: cnt stays at 0, and every tick is a boundary.
- Boundary: a tick whose next cnt value is 0. On the same edge:
  - Active period and mode load from period and center.
  - Every active duty loads from its shadow.
  - dir is set to up.
- Shadow writes:
  - duty_wr=1 with duty_sel<CHANNELS writes shadow[duty_sel] on that edge, independent of en.
  - duty_sel>=CHANNELS: the write is ignored.
  - Write coincident with a boundary: the active duty takes the pre-write shadow value. The new value applies at the following boundary.
- Compare:
  - raw[i] = (cnt < duty_active[i]); unsigned, WIDTH-bit.
  - out[i] <= raw[i] ^ polarity[i], updated only while en=1.
  - D=0 gives constant low (before polarity).
  - D>P gives constant high.
  - Edge mode high time: min(D,P+1) of P+1 ticks.
  - Center mode high time: 2D-1 of 2P ticks for 1<=D<=P.
- Mode or period changes take effect only at a boundary. There are no mid-period glitches.

## Timing
- out lags cnt by one clock: out reflects the cnt value registered on the previous edge.
- period_start is registered. It is high for exactly one clock, in the cycle during which cnt first reads 0 after a boundary.
- Shadow write at edge t is readable at t+1. It reaches out no earlier than one cycle after the next boundary.
- After rst deasserts with en=1 and prescale=0:
  - The first tick is a boundary, because active P=0. It loads period and the duties.
  - period_start pulses in the cycle after that first tick.
- rst mid-period: the next edge returns everything to reset values; the partial period is discarded.
- en deassert: all state and outputs hold exactly. On reassert, counting resumes from the held pre_cnt and cnt.

## Test plan
- Reset and basic edge mode:
  - Stimulus: rst=1 for 2 cycles, then out=0 and period_start=0; en=0; write ch0 D=3; period=9, prescale=0; en=1.
  - Required response: after the first boundary, ch0 is high 3 of every 10 cycles; period_start pulses every 10 cycles.
- Shadow update:
  - Stimulus: while D=3 is active, write ch0 D=7 at cnt=5.
  - Required response: the current period still ends with 3 high cycles; 7-high periods start after the next period_start.
  - Stimulus: a write coincident with a boundary.
  - Required response: the new value is deferred one extra period.
- Extremes:
  - P=9, D=0: constant low.
  - P=9, D=10: constant high.
  - P=255, D=255: high 255 of 256.
  - P=0: boundary every tick; period_start high continuously.
- Center mode:
  - Stimulus: P=4, D=2.
  - Required response: cnt sequence 0,1,2,3,4,3,2,1; out high for 3 of 8 ticks; period_start every 8 ticks.
  - Stimulus: switch center to 0 mid-period.
  - Required response: the switch takes effect only at the next boundary.
- Prescaler and enable:
  - Stimulus: prescale=2, P=3, D=1.
  - Required response: cnt advances every 3 enabled cycles; out is high 3 of every 12.
  - Stimulus: drop en for 5 cycles.
  - Required response: out and cnt are frozen; after en returns, the period resumes without loss.
- Polarity and select:
  - Stimulus: polarity=4'b0010, ch1 D=0.
  - Required response: out[1] is constant high.
  - Stimulus: a write with duty_sel=3, CHANNELS=3.
  - Required response: the write is ignored and all channels are unchanged.

Source files
------------

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared prescaled counter and shadowed duties
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRE_W    = 8,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PRE_W-1:0]    prescale,
  input  logic [WIDTH-1:0]    period,
  input  logic                center,
  input  logic [CHANNELS-1:0] polarity,
  input  logic                duty_wr,
  input  logic [SEL_W-1:0]    duty_sel,
  input  logic [WIDTH-1:0]    duty_data,
  output logic [CHANNELS-1:0] out,
  output logic                period_start
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  dir_e                dir_q, dir_d;
  logic [WIDTH-1:0]    per_q;
  logic                mode_q;
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [CHANNELS-1:0] out_q;
  logic                ps_q;
  logic                tick;
  logic                boundary;
  logic [CHANNELS-1:0] raw;

  always_comb begin
    tick      = en && (pre_cnt_q == prescale);
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end
    if (tick) begin
      if (per_q == '0) begin
        cnt_d = '0;
      end else if (!mode_q) begin
        cnt_d = (cnt_q >= per_q) ? '0 : cnt_q + WIDTH'(1);
      end else if (dir_q == DIR_UP) begin
        // Turn around at P; the >= guard only matters if cnt ever sits above P.
        if (cnt_q >= per_q) begin
          cnt_d = cnt_q - WIDTH'(1);
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          if (cnt_d == per_q) dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - WIDTH'(1);
      end
    end
    boundary = tick && (cnt_d == '0);
    if (boundary) dir_d = DIR_UP;
    for (int i = 0; i < CHANNELS; i++) begin
      raw[i] = cnt_q < active_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      per_q     <= '0;
      mode_q    <= 1'b0;
      out_q     <= '0;
      ps_q      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      ps_q      <= boundary;
      if (en) out_q <= raw ^ polarity;
      if (boundary) begin
        per_q  <= period;
        mode_q <= center;
      end
      // Active duties sample the shadows before any same-edge write lands.
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary) active_q[i] <= shadow_q[i];
        if (duty_wr && (duty_sel == SEL_W'(i))) shadow_q[i] <= duty_data;
      end
    end
  end

  assign out          = out_q;
  assign period_start = ps_q;

endmodule
